caravel_user_fir: RTL and testbench
===================================

Name: caravel_user_fir

Overview:
- 11-tap signed FIR accelerator in the Caravel user-project area; management SoC programs and streams it over the Wishbone slave bus (base 0x3000_0000).
- Firmware writes taps and data length, sets ap_start, pushes x samples one word at a time, pops y results; results are mirrored to mprj_io[31:16] for checking.
- Single time-multiplexed MAC; tap and sample storage in flops.

Parameters:
- NTAPS, 11, number of taps/delay-line length
- DW, 32, data/coefficient/accumulator width (two's complement)
- BASE_ADDR, 32'h3000_0000, Wishbone decode base; bits [31:8] must match

Ports:
- wb_clk_i  in  1  the one clock; all logic on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects (writes honour them per byte)
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with ack
- io_out  out  16  drives mprj_io[31:16]
- io_oeb  out  16  output enables, active-low

Behaviour:
- Reset: all taps, delay line, accumulator, data_length, counters = 0; ap_start=0, ap_done=0, ap_idle=1; wbs_ack_o=0; wbs_dat_o=0; io_out=0; io_oeb=16'hFFFF.
- Wishbone: access when stb&cyc&address match; ack asserted exactly one cycle after request, then deasserted for at least one cycle (no back-to-back ack). Unmapped offsets: writes ignored, reads 0, still acked.
- Register map (offset): 0x00 ap_ctrl {bit0 ap_start W1/RO, bit1 ap_done RO, bit2 ap_idle RO, bit4 x_ready RO, bit5 y_valid RO}; 0x10 data_length RW; 0x40+4*k tap k (k=0..10) RW; 0x80 x_in WO; 0x84 y_out RO.
- Tap writes ignored while !ap_idle.
- ap_start write (bit0=1) while ap_idle: clear delay line, sample count, ap_done; ap_idle->0; ap_start reads 1 for one cycle then self-clears. Ignored while busy.
- FSM: IDLE -> WAIT_X (x_ready=1) -> on x_in write shift delay line (d[0]=x, d[k]=d[k-1]), x_ready=0 -> MAC for NTAPS cycles, acc += tap[k]*d[k] (low DW bits, wraps) -> OUT: y_out=acc, y_valid=1 -> y_out read clears y_valid, count++ -> WAIT_X, or DONE if count==data_length.
- DONE: ap_done=1, ap_idle=1; ap_done cleared by a read of ap_ctrl (clear-on-read after returning 1).
- x_in write while x_ready=0: dropped, acked. y_out read while y_valid=0: returns last y, no state change.
- data_length=0: ap_start goes straight to DONE.
- y[n] = sum_{k=0..10} tap[k]*x[n-k], x[<0]=0.
- Async reset mid-operation returns everything to reset values immediately.

Optional Feature:
- FIR_CHECKBITS_EN: when defined, io_out <= y_out[15:0] on each y_out register update, io_oeb=16'h0000; firmware may also write marker words to offset 0xFC which load io_out directly (e.g. 16'hAB40/16'hAB51). When undefined: io_out=0, io_oeb=16'hFFFF, offset 0xFC unmapped.

Test Plan:
- Reset then read ap_ctrl -> 0x0000_0004 (idle); read tap 0x48 -> 0.
- Write taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, data_length=11, ap_start, push x=1..11 popping each y -> y = 0,-10,-29,-25,... final y=1098; ap_done=1 then cleared on second ap_ctrl read.
- With FIR_CHECKBITS_EN: write 0xFC=16'hAB40 -> io_out=16'hAB40; after run io_out tracks 16'h0000, 16'hFFF6, 16'hFFE3, 16'hFFE7, ..., 16'd1098; io_oeb=0.
- Write tap 0x40 during run -> readback unchanged; second ap_start during run ignored.
- Write x_in twice without popping y -> second x dropped; y equals single-sample result.
- Assert wb_rst_i mid-MAC -> ap_idle=1, y_valid=0, io_out=0 in the same cycle.

Source files
------------

// File: rtl/caravel_user_fir.sv
// caravel_user_fir: 11-tap signed FIR accelerator on the Caravel Wishbone slave.
// Firmware loads taps/data_length, sets ap_start, then streams x in and y out
// one word at a time. A single MAC is time-multiplexed over the taps.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   wbs_stb_i/cyc_i/we_i        Wishbone request qualifiers
//   wbs_sel_i, wbs_adr_i        byte selects, byte address
//   wbs_dat_i, wbs_dat_o        write / read data
//   wbs_ack_o                   single-cycle acknowledge
//   io_out, io_oeb              mprj_io[31:16] check bits and enables (active-low)
//
// Optional feature macro: FIR_CHECKBITS_EN
//   defined   : io_out mirrors y_out[15:0]; offset 0xFC loads io_out directly
//   undefined : io_out = 0, io_oeb = 16'hFFFF, 0xFC unmapped
//
// Register map (offset): 0x00 ap_ctrl, 0x10 data_length, 0x40+4k tap k,
//                        0x80 x_in (WO), 0x84 y_out (RO)
module caravel_user_fir #(
    parameter int          NTAPS     = 11,
    parameter int          DW        = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb
);
    localparam int AW = $clog2(NTAPS);
    localparam logic [5:0] W_CTRL = 6'd0,  W_LEN  = 6'd4,  W_TAP0 = 6'd16;
    localparam logic [5:0] W_XIN  = 6'd32, W_YOUT = 6'd33, W_MARK = 6'd63;
    localparam logic [5:0] NTAPS6 = 6'(NTAPS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_X, S_MAC, S_OUT, S_DONE} state_t;

    state_t                      state;
    logic [NTAPS-1:0][DW-1:0]    taps, dly;
    logic [DW-1:0]               acc, y_out, data_len, count;
    logic [AW-1:0]               mac_idx;
    logic                        ap_start, ap_done, ap_idle, x_ready, y_valid;
    logic                        ack;
    logic [31:0]                 rdata;

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // A request is taken only while ack is low, which guarantees the
    // idle cycle between consecutive acknowledges.
    logic        hit, req, wr, rd, tap_hit;
    logic [5:0]  word, tap_off;
    logic [31:0] wdata_x, rmux;
    logic [DW-1:0] prod, count_nxt;

    assign hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req       = hit & ~ack;
    assign wr        = req & wbs_we_i;
    assign rd        = req & ~wbs_we_i;
    assign word      = wbs_adr_i[7:2];
    assign tap_off   = word - W_TAP0;
    assign tap_hit   = (word >= W_TAP0) && (tap_off < NTAPS6);
    assign wdata_x   = merge('0, wbs_dat_i, wbs_sel_i);
    assign prod      = taps[mac_idx] * dly[mac_idx];   // low DW bits, wraps
    assign count_nxt = count + DW'(1);

    always_comb begin
        rmux = '0;
        if (word == W_CTRL)      rmux = {26'b0, y_valid, x_ready, 1'b0, ap_idle, ap_done, ap_start};
        else if (word == W_LEN)  rmux = data_len;
        else if (tap_hit)        rmux = taps[tap_off[AW-1:0]];
        else if (word == W_YOUT) rmux = y_out;
    end

`ifdef FIR_CHECKBITS_EN
    logic [15:0] io_q, oeb_q;
    assign io_out = io_q;
    assign io_oeb = oeb_q;
`else
    assign io_out = '0;
    assign io_oeb = '1;
`endif

    assign wbs_ack_o = ack;
    assign wbs_dat_o = rdata;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            taps     <= '0;
            dly      <= '0;
            acc      <= '0;
            y_out    <= '0;
            data_len <= '0;
            count    <= '0;
            mac_idx  <= '0;
            ap_start <= 1'b0;
            ap_done  <= 1'b0;
            ap_idle  <= 1'b1;
            x_ready  <= 1'b0;
            y_valid  <= 1'b0;
            ack      <= 1'b0;
            rdata    <= '0;
`ifdef FIR_CHECKBITS_EN
            io_q     <= '0;
            oeb_q    <= '1;
`endif
        end else begin
            ack      <= req;
            ap_start <= 1'b0;
            if (req) rdata <= rd ? rmux : '0;
`ifdef FIR_CHECKBITS_EN
            oeb_q <= '0;
            if (wr && word == W_MARK) io_q <= wdata_x[15:0];
`endif
            // ap_start only honoured while idle (IDLE or DONE).
            if (wr && word == W_CTRL && wbs_sel_i[0] && wbs_dat_i[0] && ap_idle) begin
                dly      <= '0;
                count    <= '0;
                ap_start <= 1'b1;
                if (data_len == '0) begin
                    ap_done <= 1'b1;
                    state   <= S_DONE;
                end else begin
                    ap_done <= 1'b0;
                    ap_idle <= 1'b0;
                    x_ready <= 1'b1;
                    state   <= S_WAIT_X;
                end
            end
            // ap_done is returned as 1 by this read, then cleared.
            if (rd && word == W_CTRL) ap_done <= 1'b0;
            if (wr && word == W_LEN) data_len <= merge(data_len, wbs_dat_i, wbs_sel_i);
            if (wr && tap_hit && ap_idle)
                taps[tap_off[AW-1:0]] <= merge(taps[tap_off[AW-1:0]], wbs_dat_i, wbs_sel_i);

            case (state)
                S_WAIT_X: if (wr && word == W_XIN && x_ready) begin
                    dly[0] <= wdata_x;
                    for (int k = 1; k < NTAPS; k++) dly[k] <= dly[k-1];
                    x_ready <= 1'b0;
                    acc     <= '0;
                    mac_idx <= '0;
                    state   <= S_MAC;
                end
                S_MAC: begin
                    acc     <= acc + prod;
                    mac_idx <= mac_idx + AW'(1);
                    if (mac_idx == AW'(NTAPS - 1)) begin
                        y_out   <= acc + prod;
                        y_valid <= 1'b1;
`ifdef FIR_CHECKBITS_EN
                        io_q    <= 16'(acc + prod);
`endif
                        state   <= S_OUT;
                    end
                end
                S_OUT: if (rd && word == W_YOUT && y_valid) begin
                    y_valid <= 1'b0;
                    count   <= count_nxt;
                    if (count_nxt == data_len) begin
                        ap_done <= 1'b1;
                        ap_idle <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        x_ready <= 1'b1;
                        state   <= S_WAIT_X;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_caravel_user_fir.sv
module tb_caravel_user_fir;
    localparam logic [31:0] B = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [15:0] io_out, io_oeb;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;
    vec_t vecs[11];
    logic [31:0] tapv[11];

    caravel_user_fir dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .io_out(io_out), .io_oeb(io_oeb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One Wishbone transfer; returns read data and cycles until ack.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output int lat);
        @(negedge clk);
        stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 20);
        r = rdat;
        if (!ack) check("ack_timeout", {31'b0, ack}, 32'd1);
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic wb_wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] r;
        int lat;
        wb_xfer(1'b1, B + off, d, s, r, lat);
    endtask

    task automatic wb_rd(input logic [31:0] off, output logic [31:0] r);
        int lat;
        wb_xfer(1'b0, B + off, '0, 4'hF, r, lat);
    endtask

    task automatic wait_y();
        logic [31:0] r;
        int n;
        n = 0;
        do begin
            wb_rd(32'h00, r);
            n++;
        end while (!r[5] && n < 30);
        check("y_valid_wait", {31'b0, r[5]}, 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        int lat;
        int n;

        tapv = '{32'd0, -32'sd10, -32'sd9, 32'd23, 32'd56, 32'd63, 32'd56, 32'd23,
                 -32'sd9, -32'sd10, 32'd0};
        vecs[0]  = '{32'd1,  32'd0};
        vecs[1]  = '{32'd2,  -32'sd10};
        vecs[2]  = '{32'd3,  -32'sd29};
        vecs[3]  = '{32'd4,  -32'sd25};
        vecs[4]  = '{32'd5,  32'd35};
        vecs[5]  = '{32'd6,  32'd158};
        vecs[6]  = '{32'd7,  32'd337};
        vecs[7]  = '{32'd8,  32'd539};
        vecs[8]  = '{32'd9,  32'd732};
        vecs[9]  = '{32'd10, 32'd915};
        vecs[10] = '{32'd11, 32'd1098};

        rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_io_out", {16'b0, io_out}, 32'd0);
        check("rst_io_oeb", {16'b0, io_oeb}, 32'h0000_FFFF);
        rst = 0;

        // Reset state and ack timing.
        wb_xfer(1'b0, B, '0, 4'hF, r, lat);
        check("ctrl_reset", r, 32'h4);
        check("ack_latency", lat, 1);
        @(negedge clk);
        check("ack_drops", {31'b0, ack}, 32'd0);
        wb_rd(32'h48, r);
        check("tap2_reset", r, 32'd0);

        // Foreign base address: never acked.
        @(negedge clk);
        stb = 1; cyc = 1; we = 0; adr = 32'h3100_0000; sel = 4'hF;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack) n++;
        end
        stb = 0; cyc = 0;
        check("foreign_no_ack", n, 0);

        // Unmapped offset and byte selects.
        wb_wr(32'h20, 32'hDEAD_BEEF);
        wb_rd(32'h20, r);
        check("unmapped_rd", r, 32'd0);
        wb_wr(32'h10, 32'hFFFF_FF0B, 4'b0001);
        wb_rd(32'h10, r);
        check("len_bytesel", r, 32'd11);

        for (int k = 0; k < 11; k++) wb_wr(32'h40 + 4 * k, tapv[k]);
        wb_rd(32'h4C, r);
        check("tap3_rd", r, 32'd23);

`ifdef FIR_CHECKBITS_EN
        wb_wr(32'hFC, 32'h0000_AB40);
        check("marker_io", {16'b0, io_out}, 32'h0000_AB40);
        check("oeb_on", {16'b0, io_oeb}, 32'd0);
`endif

        // Main run.
        wb_wr(32'h00, 32'h1);
        wb_rd(32'h00, r);
        check("ctrl_xready", r, 32'h10);
        wb_wr(32'h44, 32'd99);
        wb_rd(32'h44, r);
        check("tap_locked", r, -32'sd10);

        for (int i = 0; i < 11; i++) begin
            wb_wr(32'h80, vecs[i].x);
            wait_y();
            if (i == 0) begin
                wb_wr(32'h00, 32'h1);
                wb_rd(32'h00, r);
                check("start_ignored", r, 32'h20);
            end
            wb_rd(32'h84, r);
            check($sformatf("y[%0d]", i), r, vecs[i].y);
`ifdef FIR_CHECKBITS_EN
            check($sformatf("io_y[%0d]", i), {16'b0, io_out}, {16'b0, vecs[i].y[15:0]});
`else
            check($sformatf("io_y[%0d]", i), {16'b0, io_out}, 32'd0);
`endif
        end
        wb_rd(32'h84, r);
        check("y_reread", r, 32'd1098);
        wb_rd(32'h00, r);
        check("ctrl_done", r, 32'h6);
        wb_rd(32'h00, r);
        check("ctrl_done_clr", r, 32'h4);

        // Second x while busy is dropped; delay line cleared by ap_start.
        wb_wr(32'h40, 32'd3);
        wb_wr(32'h10, 32'd2);
        wb_wr(32'h00, 32'h1);
        wb_wr(32'h80, 32'd5);
        wb_wr(32'h80, 32'd7);
        wait_y();
        wb_rd(32'h84, r);
        check("drop_y0", r, 32'd15);
        wb_wr(32'h80, 32'd2);
        wait_y();
        wb_rd(32'h84, r);
        check("drop_y1", r, -32'sd44);
        wb_rd(32'h00, r);
        check("drop_done", r, 32'h6);

        // data_length = 0 finishes immediately.
        wb_wr(32'h10, 32'd0);
        wb_wr(32'h00, 32'h1);
        wb_rd(32'h00, r);
        check("len0_done", r, 32'h6);
        wb_rd(32'h00, r);
        check("len0_clr", r, 32'h4);

        // Async reset in the middle of MAC.
        wb_wr(32'h10, 32'd1);
        wb_wr(32'h00, 32'h1);
        wb_wr(32'h80, 32'd9);
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1;
        check("mid_rst_io", {16'b0, io_out}, 32'd0);
        check("mid_rst_oeb", {16'b0, io_oeb}, 32'h0000_FFFF);
        check("mid_rst_ack", {31'b0, ack}, 32'd0);
        @(negedge clk);
        rst = 0;
        wb_rd(32'h00, r);
        check("post_rst_ctrl", r, 32'h4);
        wb_rd(32'h84, r);
        check("post_rst_y", r, 32'd0);
        wb_rd(32'h40, r);
        check("post_rst_tap", r, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
